// File: rtl/procyon_vq_pkg.sv
// Helper functions for the victim queue: CCU length code for a line size.
`include "procyon_constants.svh"

package procyon_vq_pkg;

  // Map a cacheline size in bytes onto the CCU length code; unsupported
  // sizes fall back to the 4-byte code.
  function automatic logic [`PCYN_CCU_LEN_WIDTH-1:0] ccu_len_code(input int line_size);
    logic [`PCYN_CCU_LEN_WIDTH-1:0] code;
    case (line_size)
      4:       code = `PCYN_CCU_LEN_4B;
      8:       code = `PCYN_CCU_LEN_8B;
      16:      code = `PCYN_CCU_LEN_16B;
      32:      code = `PCYN_CCU_LEN_32B;
      64:      code = `PCYN_CCU_LEN_64B;
      128:     code = `PCYN_CCU_LEN_128B;
      default: code = `PCYN_CCU_LEN_4B;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/procyon_constants.svh
// Shared constants for the Procyon core: CCU request length codes.
`ifndef PROCYON_CONSTANTS_SVH
`define PROCYON_CONSTANTS_SVH

`define PCYN_CCU_LEN_WIDTH 4

`define PCYN_CCU_LEN_1B    4'd0
`define PCYN_CCU_LEN_2B    4'd1
`define PCYN_CCU_LEN_4B    4'd2
`define PCYN_CCU_LEN_8B    4'd3
`define PCYN_CCU_LEN_16B   4'd4
`define PCYN_CCU_LEN_32B   4'd5
`define PCYN_CCU_LEN_64B   4'd6
`define PCYN_CCU_LEN_128B  4'd7

`endif

// File: rtl/procyon_queue_ctrl.sv
// Head/tail pointer management for a circular queue of arbitrary depth.
module procyon_queue_ctrl #(
  parameter int OPTN_QUEUE_DEPTH = 8,
  parameter int QUEUE_IDX_WIDTH  = (OPTN_QUEUE_DEPTH == 1 ? 1 : $clog2(OPTN_QUEUE_DEPTH))
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_flush,
  input  logic                       i_incr_head,
  input  logic                       i_incr_tail,
  output logic [QUEUE_IDX_WIDTH-1:0] o_queue_head,
  output logic [QUEUE_IDX_WIDTH-1:0] o_queue_tail
);

  localparam logic [QUEUE_IDX_WIDTH-1:0] LAST_IDX = QUEUE_IDX_WIDTH'(OPTN_QUEUE_DEPTH - 1);

  logic [QUEUE_IDX_WIDTH-1:0] head_next;
  logic [QUEUE_IDX_WIDTH-1:0] tail_next;

  // Wrap explicitly at the last index so non-power-of-2 depths work too.
  always_comb begin
    head_next = (o_queue_head == LAST_IDX) ? '0 : o_queue_head + 1'b1;
    tail_next = (o_queue_tail == LAST_IDX) ? '0 : o_queue_tail + 1'b1;
  end

  // Advance each pointer independently; flush and reset return both to zero.
  always_ff @(posedge clk) begin
    if (!n_rst || i_flush) begin
      o_queue_head <= '0;
      o_queue_tail <= '0;
    end else begin
      if (i_incr_head) o_queue_head <= head_next;
      if (i_incr_tail) o_queue_tail <= tail_next;
    end
  end

endmodule

// File: rtl/procyon_vq_entry.sv
// One victim queue slot: valid bit, line address (tag), line data and the
// CAM compare against the LSU lookup line.
module procyon_vq_entry #(
  parameter int TAG_WIDTH  = 27,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_alloc,
  input  logic                  i_clear,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic [LINE_WIDTH-1:0] i_data,
  input  logic [TAG_WIDTH-1:0]  i_lookup_tag,
  output logic                  o_valid,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [LINE_WIDTH-1:0] o_data,
  output logic                  o_match
);

  // Set on allocate, clear when the CCU finishes writing this entry back.
  always_ff @(posedge clk) begin
    if (!n_rst)       o_valid <= 1'b0;
    else if (i_alloc) o_valid <= 1'b1;
    else if (i_clear) o_valid <= 1'b0;
  end

  // Payload needs no reset; it is only observed while the entry is valid.
  always_ff @(posedge clk) begin
    if (i_alloc) begin
      o_tag  <= i_tag;
      o_data <= i_data;
    end
  end

  assign o_match = o_valid & (o_tag == i_lookup_tag);

endmodule

// File: rtl/procyon_vq.sv
// Victim queue: buffers dirty lines evicted by MHQ fills and writes them back
// through the CCU in FIFO order, with a same-cycle line CAM for the LSU.
`include "procyon_constants.svh"

module procyon_vq
  import procyon_vq_pkg::*;
#(
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_VQ_DEPTH     = 4,
  parameter int OPTN_DC_LINE_SIZE = 1024,
  parameter int VQ_IDX_WIDTH      = (OPTN_VQ_DEPTH == 1 ? 1 : $clog2(OPTN_VQ_DEPTH)),
  parameter int DC_LINE_WIDTH     = OPTN_DC_LINE_SIZE * 8
) (
  input  logic                           clk,
  input  logic                           n_rst,

  input  logic                           i_vq_victim_valid,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_vq_victim_addr,
  input  logic [DC_LINE_WIDTH-1:0]       i_vq_victim_data,
  output logic                           o_vq_full,

  input  logic                           i_vq_lookup_valid,
  input  logic [OPTN_ADDR_WIDTH-1:0]     i_vq_lookup_addr,
  output logic                           o_vq_lookup_hit,

  input  logic                           i_ccu_done,
  output logic                           o_ccu_en,
  output logic                           o_ccu_we,
  output logic [`PCYN_CCU_LEN_WIDTH-1:0] o_ccu_len,
  output logic [OPTN_ADDR_WIDTH-1:0]     o_ccu_addr,
  output logic [DC_LINE_WIDTH-1:0]       o_ccu_data
);

  localparam int OFFSET_WIDTH = $clog2(OPTN_DC_LINE_SIZE);
  localparam int TAG_WIDTH    = OPTN_ADDR_WIDTH - OFFSET_WIDTH;

  logic [VQ_IDX_WIDTH-1:0]  head;
  logic [VQ_IDX_WIDTH-1:0]  tail;
  logic [OPTN_VQ_DEPTH-1:0] entry_valid;
  logic [OPTN_VQ_DEPTH-1:0] entry_match;
  logic [TAG_WIDTH-1:0]     entry_tag  [OPTN_VQ_DEPTH];
  logic [DC_LINE_WIDTH-1:0] entry_data [OPTN_VQ_DEPTH];

  logic                     enq_accept;
  logic                     wb_done;
  logic [TAG_WIDTH-1:0]     victim_tag;
  logic [TAG_WIDTH-1:0]     lookup_tag;

  // Byte-offset bits carry no meaning for a whole-line queue.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{i_vq_victim_addr[OFFSET_WIDTH-1:0],
                                i_vq_lookup_addr[OFFSET_WIDTH-1:0]};

  assign victim_tag = i_vq_victim_addr[OPTN_ADDR_WIDTH-1:OFFSET_WIDTH];
  assign lookup_tag = i_vq_lookup_addr[OPTN_ADDR_WIDTH-1:OFFSET_WIDTH];

  // A victim offered while full is dropped; fills are gated on o_vq_full so
  // this only happens on a protocol violation upstream.
  assign enq_accept = i_vq_victim_valid & ~o_vq_full;
  assign wb_done    = i_ccu_done & o_ccu_en;

  procyon_queue_ctrl #(
    .OPTN_QUEUE_DEPTH (OPTN_VQ_DEPTH),
    .QUEUE_IDX_WIDTH  (VQ_IDX_WIDTH)
  ) queue_ctrl_inst (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_flush      (1'b0),
    .i_incr_head  (wb_done),
    .i_incr_tail  (enq_accept),
    .o_queue_head (head),
    .o_queue_tail (tail)
  );

  genvar gi;
  generate
    for (gi = 0; gi < OPTN_VQ_DEPTH; gi++) begin : gen_entry
      procyon_vq_entry #(
        .TAG_WIDTH  (TAG_WIDTH),
        .LINE_WIDTH (DC_LINE_WIDTH)
      ) entry_inst (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_alloc      (enq_accept & (tail == VQ_IDX_WIDTH'(gi))),
        .i_clear      (wb_done & (head == VQ_IDX_WIDTH'(gi))),
        .i_tag        (victim_tag),
        .i_data       (i_vq_victim_data),
        .i_lookup_tag (lookup_tag),
        .o_valid      (entry_valid[gi]),
        .o_tag        (entry_tag[gi]),
        .o_data       (entry_data[gi]),
        .o_match      (entry_match[gi])
      );
    end
  endgenerate

  // Full and write-back request come straight from entry/pointer registers,
  // so the MHQ fill gate and CCU request have no combinational input paths.
  assign o_vq_full  = &entry_valid;
  assign o_ccu_en   = entry_valid[head];
  assign o_ccu_we   = 1'b1;
  assign o_ccu_len  = ccu_len_code(OPTN_DC_LINE_SIZE);
  assign o_ccu_addr = {entry_tag[head], {OFFSET_WIDTH{1'b0}}};
  assign o_ccu_data = entry_data[head];

  // The incoming victim is included so a line never falls through the gap
  // between leaving the dcache and landing in an entry.
  assign o_vq_lookup_hit = i_vq_lookup_valid &
                           ((|entry_match) | (enq_accept & (victim_tag == lookup_tag)));

endmodule

// File: doc/procyon_vq.md
Name: procyon_vq

Overview:
- Victim queue: buffers dirty cachelines evicted from the dcache when MHQ fills are installed.
- Writes each buffered line back to memory through the CCU, in FIFO order.
- Sits downstream of the MHQ fill path. Its full flag gates MHQ fill launches, so every fill always has a place for its victim.
- Provides a same-cycle line-address CAM so the LSU can retry accesses to lines still in flight to memory.

Parameters:
- OPTN_ADDR_WIDTH, 32, address width in bits.
- OPTN_VQ_DEPTH, 4, number of victim entries.
- OPTN_DC_LINE_SIZE, 1024, cacheline size in bytes (power of 2, at least 4).
- VQ_IDX_WIDTH, (OPTN_VQ_DEPTH == 1 ? 1 : $clog2(OPTN_VQ_DEPTH)), head/tail pointer width.
- DC_LINE_WIDTH, OPTN_DC_LINE_SIZE*8, cacheline width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- n_rst  in  1  reset, synchronous, active-low.
- i_vq_victim_valid  in  1  dcache presents an evicted dirty line this cycle.
- i_vq_victim_addr  in  OPTN_ADDR_WIDTH  victim address; offset bits ignored.
- i_vq_victim_data  in  DC_LINE_WIDTH  victim line data.
- o_vq_full  out  1  all entries valid; gates MHQ fill enable.
- i_vq_lookup_valid  in  1  LSU lookup request.
- i_vq_lookup_addr  in  OPTN_ADDR_WIDTH  lookup address; offset bits ignored.
- o_vq_lookup_hit  out  1  lookup line matches a valid entry or the incoming victim.
- i_ccu_done  in  1  CCU write of the head entry complete (one-cycle pulse).
- o_ccu_en  out  1  write-back request for the head entry.
- o_ccu_we  out  1  constant 1.
- o_ccu_len  out  `PCYN_CCU_LEN_WIDTH  length code for OPTN_DC_LINE_SIZE.
- o_ccu_addr  out  OPTN_ADDR_WIDTH  head line address, offset bits zero.
- o_ccu_data  out  DC_LINE_WIDTH  head line data.

Behaviour:
- Reset (n_rst low at a clock edge):
  - All entries invalid; head = tail = 0.
  - o_vq_full = 0, o_ccu_en = 0, o_vq_lookup_hit = 0.
  - o_ccu_addr/o_ccu_data are don't-care while o_ccu_en = 0.
  - Reset mid-write-back abandons the entry; the CCU is reset with the core.
- Enqueue:
  - When i_vq_victim_valid & ~o_vq_full, the entry at tail is written with the line address and data. It is valid next cycle and tail increments modulo OPTN_VQ_DEPTH.
  - If i_vq_victim_valid is asserted while o_vq_full = 1, the victim is dropped and no state changes. This is a protocol violation; the bench asserts it never happens.
- Write-back:
  - o_ccu_en = valid[head], driven from registers only.
  - o_ccu_addr, o_ccu_data and o_ccu_len are held stable while o_ccu_en = 1 until i_ccu_done.
  - On i_ccu_done with o_ccu_en = 1: head entry is invalidated and head increments at that edge.
  - If the next entry is valid, o_ccu_en stays high and presents the next entry in the following cycle (one request per entry, no bubble required).
  - i_ccu_done while o_ccu_en = 0 is ignored.
- Full flag:
  - o_vq_full = all entries valid, from registers.
  - Simultaneous enqueue and done while not full: both take effect; count is unchanged.
  - Done while full: o_vq_full drops the next cycle. A victim offered in the done cycle is still refused.
- Lookup:
  - o_vq_lookup_hit = i_vq_lookup_valid & (any valid entry line address == lookup line address, or (i_vq_victim_valid & ~o_vq_full & victim line == lookup line)).
  - Combinational, same cycle.
  - The head entry still hits in its i_ccu_done cycle and stops hitting the cycle after.
- Ordering:
  - Strict FIFO; pointers wrap at OPTN_VQ_DEPTH.
  - Duplicate line addresses are legal and are written back in order.
- o_ccu_len by line size: 4 → `PCYN_CCU_LEN_4B, 8 → 8B, 16 → 16B, 32 → 32B, 64 → 64B, 128 → 128B; any other size → `PCYN_CCU_LEN_4B.

Decomposition:
- CCU length codes and `PCYN_CCU_LEN_WIDTH stay in procyon_constants.svh; no new package types.
- Pointer management reuses procyon_queue_ctrl:
  - incr_tail = enqueue accepted.
  - incr_head = i_ccu_done & o_ccu_en.
  - flush = 0.
- One sub-module, procyon_vq_entry:
  - Holds valid, line address and data.
  - Performs the per-entry CAM compare.
  - Handles set-on-allocate and clear-on-done.

Test Plan (DEPTH=4, LINE_SIZE=32, ADDR_WIDTH=32):
- Reset held 2 cycles → o_ccu_en = 0, o_vq_full = 0, o_vq_lookup_hit = 0, o_ccu_we = 1, o_ccu_len = `PCYN_CCU_LEN_32B.
- Victim 0x1004 with data pattern A; done pulsed 5 cycles later → o_ccu_addr = 0x1000 and data = A from the next cycle until done; o_ccu_en = 0 the cycle after done.
- 4 victims (0x1000, 0x2000, 0x3000, 0x4000) with done withheld → o_vq_full = 1 after the 4th; 5th victim dropped (assertion fires). Done pulse → full = 0 next cycle and o_ccu_addr = 0x2000.
- Entry 0x1000 queued → lookup 0x101C gives hit = 1, lookup 0x1020 gives hit = 0, lookup_valid = 0 gives hit = 0.
- Victim 0x5000 and lookup 0x5008 in the same cycle → hit = 1. Head done-cycle lookup → hit = 1; the following cycle → hit = 0.
- 10 victims, each done 3 cycles after o_ccu_en, enqueues interleaved including same-cycle enqueue+done → all 10 addresses and data written back in order through pointer wrap, with no loss.
